// File: rtl/banco_pkg.sv
// Shared constants and index type for the calculator register bank and its scoreboard.
package banco_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 4;
  localparam int ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
  localparam int ACC_IDX_DEF  = 2;
  localparam int ZERO_IDX_DEF = NUM_REGS_DEF - 1;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/banco_scoreboard.sv
// Per-register pending bits for outstanding multi-cycle results, and the decode stall.
module banco_scoreboard
  import banco_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_IDX = NUM_REGS - 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_idx_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_idx1_i,
  input  logic [ADDR_W-1:0] rd_idx2_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_idx_i,
  output logic              busy_o
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic                src1_pend_s;
  logic                src2_pend_s;

  // Next pending state: a write clears, a reserve then sets, so reserve wins on the same index.
  always_comb begin
    pending_d = pending_q;
    if (wr_en_i) begin
      pending_d[wr_idx_i] = 1'b0;
    end else begin
      pending_d[wr_idx_i] = pending_q[wr_idx_i];
    end
    if (rsv_en_i && (rsv_idx_i != ZERO_A)) begin
      pending_d[rsv_idx_i] = 1'b1;
    end else begin
      pending_d[rsv_idx_i] = pending_d[rsv_idx_i];
    end
    pending_d[ZERO_IDX] = 1'b0;
  end

  // Pending bit storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A same-cycle write to a source resolves it through the bypass, so it no longer stalls.
  always_comb begin
    src1_pend_s = pending_q[rd_idx1_i] & ~(wr_en_i & (wr_idx_i == rd_idx1_i));
    src2_pend_s = pending_q[rd_idx2_i] & ~(wr_en_i & (wr_idx_i == rd_idx2_i));
    busy_o      = rd_req_i & (src1_pend_s | src2_pend_s);
  end

endmodule

// File: rtl/banco_reg_pipe.sv
// Register bank: one write port, two registered read ports with write bypass,
// pending scoreboard stall and a clearable accumulator register.
module banco_reg_pipe
  import banco_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ACC_IDX  = ACC_IDX_DEF,
  parameter int ZERO_IDX = NUM_REGS - 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              Escrita,
  input  logic [ADDR_W-1:0] IdReg,
  input  logic [DATA_W-1:0] Dado,
  input  logic              Leitura,
  input  logic [ADDR_W-1:0] Fonte1,
  input  logic [ADDR_W-1:0] Fonte2,
  input  logic              Reserva,
  input  logic [ADDR_W-1:0] IdReserva,
  input  logic              LimpaAcc,
  output logic              Ocupado,
  output logic              Valido,
  output logic [DATA_W-1:0] DadoLido1,
  output logic [DATA_W-1:0] DadoLido2,
  output logic [DATA_W-1:0] Acumulador
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] ACC_A  = ADDR_W'(ACC_IDX);

  logic [DATA_W-1:0] reg_q [NUM_REGS];
  logic [DATA_W-1:0] reg_d [NUM_REGS];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              valid_q, valid_d;
  logic              busy_s;

  function automatic logic [DATA_W-1:0] read_val(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_idx,
    input logic [DATA_W-1:0] wr_data,
    input logic              clr_acc
  );
    logic [DATA_W-1:0] v;
    if (idx == ZERO_A) begin
      v = '0;
    end else if (idx == ACC_A && clr_acc) begin
      v = '0;
    end else if (wr_en && (wr_idx == idx)) begin
      v = wr_data;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  banco_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_IDX (ZERO_IDX)
  ) u_scoreboard (
    .clk_i     (Clock),
    .rst_ni    (Reset_n),
    .wr_en_i   (Escrita),
    .wr_idx_i  (IdReg),
    .rd_req_i  (Leitura),
    .rd_idx1_i (Fonte1),
    .rd_idx2_i (Fonte2),
    .rsv_en_i  (Reserva),
    .rsv_idx_i (IdReserva),
    .busy_o    (busy_s)
  );

  // Register file next state: write, then accumulator clear overriding it; zero reg stays 0.
  always_comb begin
    reg_d = reg_q;
    if (Escrita && (IdReg != ZERO_A)) begin
      reg_d[IdReg] = Dado;
    end else begin
      reg_d[IdReg] = reg_q[IdReg];
    end
    if (LimpaAcc) begin
      reg_d[ACC_IDX] = '0;
    end else begin
      reg_d[ACC_IDX] = reg_d[ACC_IDX];
    end
    reg_d[ZERO_IDX] = '0;
  end

  // Read ports capture on an accepted read and hold otherwise.
  always_comb begin
    if (Leitura && !busy_s) begin
      rd1_d   = read_val(Fonte1, reg_q[Fonte1], Escrita, IdReg, Dado, LimpaAcc);
      rd2_d   = read_val(Fonte2, reg_q[Fonte2], Escrita, IdReg, Dado, LimpaAcc);
      valid_d = 1'b1;
    end else begin
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      valid_d = 1'b0;
    end
  end

  // Storage and read-port registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
      rd1_q   <= '0;
      rd2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      valid_q <= valid_d;
    end
  end

  assign Ocupado    = busy_s;
  assign Valido     = valid_q;
  assign DadoLido1  = rd1_q;
  assign DadoLido2  = rd2_q;
  assign Acumulador = reg_q[ACC_IDX];

endmodule

// File: tb/tb_banco_reg_pipe.sv
// Directed self-checking bench for banco_reg_pipe (default 4 x 32 configuration).
module tb_banco_reg_pipe;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Escrita;
  logic [1:0]  IdReg;
  logic [31:0] Dado;
  logic        Leitura;
  logic [1:0]  Fonte1;
  logic [1:0]  Fonte2;
  logic        Reserva;
  logic [1:0]  IdReserva;
  logic        LimpaAcc;
  logic        Ocupado;
  logic        Valido;
  logic [31:0] DadoLido1;
  logic [31:0] DadoLido2;
  logic [31:0] Acumulador;

  int vectors    = 0;
  int miscompares = 0;

  banco_reg_pipe dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Escrita    (Escrita),
    .IdReg      (IdReg),
    .Dado       (Dado),
    .Leitura    (Leitura),
    .Fonte1     (Fonte1),
    .Fonte2     (Fonte2),
    .Reserva    (Reserva),
    .IdReserva  (IdReserva),
    .LimpaAcc   (LimpaAcc),
    .Ocupado    (Ocupado),
    .Valido     (Valido),
    .DadoLido1  (DadoLido1),
    .DadoLido2  (DadoLido2),
    .Acumulador (Acumulador)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    Escrita = 1'b0; IdReg = 2'd0; Dado = 32'h0;
    Leitura = 1'b0; Fonte1 = 2'd0; Fonte2 = 2'd0;
    Reserva = 1'b0; IdReserva = 2'd0; LimpaAcc = 1'b0;
  endtask

  initial begin
    idle();
    Reset_n = 1'b0;
    #12;
    check("rst_valido", {31'd0, Valido}, 32'd0);
    check("rst_lido1", DadoLido1, 32'h0);
    check("rst_lido2", DadoLido2, 32'h0);
    check("rst_acc", Acumulador, 32'h0);
    Reset_n = 1'b1;
    step();

    // write 0xAA to reg0, then read reg0 and the zero register
    Escrita = 1'b1; IdReg = 2'd0; Dado = 32'h0000_00AA;
    step();
    Escrita = 1'b0; Leitura = 1'b1; Fonte1 = 2'd0; Fonte2 = 2'd3;
    step();
    check("rd_lido1", DadoLido1, 32'h0000_00AA);
    check("rd_lido2", DadoLido2, 32'h0);
    check("rd_valido", {31'd0, Valido}, 32'd1);
    Leitura = 1'b0;
    step();
    check("idle_valido", {31'd0, Valido}, 32'd0);
    check("idle_hold1", DadoLido1, 32'h0000_00AA);

    // bypass: write reg1 and read it in the same cycle
    Escrita = 1'b1; IdReg = 2'd1; Dado = 32'h0000_1234;
    Leitura = 1'b1; Fonte1 = 2'd1; Fonte2 = 2'd0;
    step();
    check("byp_lido1", DadoLido1, 32'h0000_1234);
    check("byp_lido2", DadoLido2, 32'h0000_00AA);
    idle();

    // scoreboard: reserve reg1, read stalls, write releases it with bypass
    Reserva = 1'b1; IdReserva = 2'd1;
    step();
    Reserva = 1'b0; Leitura = 1'b1; Fonte1 = 2'd0; Fonte2 = 2'd1;
    #1;
    check("sb_ocupado", {31'd0, Ocupado}, 32'd1);
    step();
    check("sb_stall_valido", {31'd0, Valido}, 32'd0);
    check("sb_stall_hold2", DadoLido2, 32'h0000_00AA);
    Escrita = 1'b1; IdReg = 2'd1; Dado = 32'h0000_0055;
    #1;
    check("sb_release_ocupado", {31'd0, Ocupado}, 32'd0);
    step();
    check("sb_lido2", DadoLido2, 32'h0000_0055);
    check("sb_lido1", DadoLido1, 32'h0000_00AA);
    check("sb_valido", {31'd0, Valido}, 32'd1);
    Escrita = 1'b0;
    #1;
    check("sb_cleared_ocupado", {31'd0, Ocupado}, 32'd0);

    // reserve and write to the same index: reserve wins, data still written
    idle();
    Reserva = 1'b1; IdReserva = 2'd0; Escrita = 1'b1; IdReg = 2'd0; Dado = 32'h0000_00BB;
    step();
    idle();
    Leitura = 1'b1; Fonte1 = 2'd0; Fonte2 = 2'd1;
    #1;
    check("rsvwr_ocupado", {31'd0, Ocupado}, 32'd1);
    Leitura = 1'b0;
    Escrita = 1'b1; IdReg = 2'd0; Dado = 32'h0000_00CC;
    step();
    idle();
    Leitura = 1'b1; Fonte1 = 2'd0; Fonte2 = 2'd0;
    #1;
    check("rsvwr_clear_ocupado", {31'd0, Ocupado}, 32'd0);
    step();
    check("same_idx_lido1", DadoLido1, 32'h0000_00CC);
    check("same_idx_lido2", DadoLido2, 32'h0000_00CC);

    // accumulator clear beats a same-cycle write, bypass read also sees 0
    idle();
    Escrita = 1'b1; IdReg = 2'd2; Dado = 32'h0000_0007; LimpaAcc = 1'b1;
    Leitura = 1'b1; Fonte1 = 2'd2; Fonte2 = 2'd1;
    step();
    check("acc_cleared", Acumulador, 32'h0);
    check("acc_byp_lido1", DadoLido1, 32'h0);
    check("acc_lido2", DadoLido2, 32'h0000_0055);
    idle();
    Escrita = 1'b1; IdReg = 2'd2; Dado = 32'h0000_0009;
    #1;
    check("acc_no_bypass", Acumulador, 32'h0);
    step();
    check("acc_written", Acumulador, 32'h0000_0009);
    idle();
    LimpaAcc = 1'b1;
    step();
    check("acc_clear_only", Acumulador, 32'h0);

    // zero register: writes and reserves are ignored
    idle();
    Escrita = 1'b1; IdReg = 2'd3; Dado = 32'hFFFF_FFFF;
    Reserva = 1'b1; IdReserva = 2'd3;
    Leitura = 1'b1; Fonte1 = 2'd3; Fonte2 = 2'd3;
    #1;
    check("zero_ocupado", {31'd0, Ocupado}, 32'd0);
    step();
    check("zero_lido1", DadoLido1, 32'h0);
    check("zero_lido2", DadoLido2, 32'h0);
    check("zero_valido", {31'd0, Valido}, 32'd1);
    idle();
    Leitura = 1'b1; Fonte1 = 2'd3; Fonte2 = 2'd0;
    #1;
    check("zero_after_ocupado", {31'd0, Ocupado}, 32'd0);
    step();
    check("zero_after_lido1", DadoLido1, 32'h0);

    // reset in the middle of a read
    idle();
    Escrita = 1'b1; IdReg = 2'd2; Dado = 32'h0000_0077;
    Leitura = 1'b1; Fonte1 = 2'd0; Fonte2 = 2'd1;
    step();
    check("pre_rst_lido1", DadoLido1, 32'h0000_00CC);
    check("pre_rst_acc", Acumulador, 32'h0000_0077);
    Escrita = 1'b0;
    #2;
    Reset_n = 1'b0;
    #1;
    check("mid_rst_valido", {31'd0, Valido}, 32'd0);
    check("mid_rst_lido1", DadoLido1, 32'h0);
    check("mid_rst_lido2", DadoLido2, 32'h0);
    check("mid_rst_acc", Acumulador, 32'h0);
    Leitura = 1'b0;
    #2;
    Reset_n = 1'b1;
    step();
    check("post_rst_valido", {31'd0, Valido}, 32'd0);
    Leitura = 1'b1; Fonte1 = 2'd0; Fonte2 = 2'd1;
    step();
    check("post_rst_reg0", DadoLido1, 32'h0);
    check("post_rst_reg1", DadoLido2, 32'h0);
    check("post_rst_valido2", {31'd0, Valido}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
